// File: rtl/note_judge.sv
// note_judge: judges each falling note once as hit/miss and keeps score, combo and max_combo.
// Latency: button to hit/miss pulse is 3 clocks; no backpressure, all outputs are single-cycle pulses or counters.
module note_judge #(
    parameter int Y_HIT      = 40,
    parameter int HIT_WIN    = 8,
    parameter int HIT_POINTS = 10
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        note_new,
    input  logic [3:0]  note_cmd,
    input  logic [7:0]  note_y,
    input  logic [3:0]  btn,
    output logic        hit,
    output logic        miss,
    output logic        note_clear,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_JUDGED = 2'd2;

    localparam logic [7:0] WIN_LO = 8'(Y_HIT - HIT_WIN);
    localparam logic [7:0] WIN_HI = 8'(Y_HIT + HIT_WIN);

    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  state_q, state_d;
    logic        hit_q, hit_d, miss_q, miss_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d, max_q, max_d;

    logic [3:0]  edges;
    logic [3:0]  mask_hit;
    logic        in_win, passed;
    logic [16:0] score_sum;
    logic [7:0]  combo_inc;

    assign edges     = sync2_q & ~prev_q;
    assign mask_hit  = mask_q | edges;
    assign in_win    = (note_y >= WIN_LO) && (note_y <= WIN_HI);
    assign passed    = note_y < WIN_LO;
    assign score_sum = {1'b0, score_q} + 17'(HIT_POINTS);
    assign combo_inc = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        mask_d  = mask_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;

        case (state_q)
            S_IDLE: begin
                if (note_new) begin
                    state_d = S_ARMED;
                    mask_d  = 4'd0;
                end
            end
            S_ARMED: begin
                // A fresh note while still armed means the old one went unjudged.
                if (note_new) begin
                    miss_d = 1'b1;
                    mask_d = 4'd0;
                end else if (in_win && ((edges & ~note_cmd) != 4'd0)) begin
                    miss_d  = 1'b1;
                    state_d = S_JUDGED;
                end else if (in_win && (mask_hit == note_cmd) && (note_cmd != 4'd0)) begin
                    hit_d   = 1'b1;
                    state_d = S_JUDGED;
                end else if (in_win) begin
                    mask_d = mask_hit;
                end else if (passed) begin
                    miss_d  = 1'b1;
                    state_d = S_JUDGED;
                end
            end
            S_JUDGED: begin
                if (note_new) begin
                    state_d = S_ARMED;
                    mask_d  = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hit_d) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            combo_d = combo_inc;
            max_d   = (combo_inc > max_q) ? combo_inc : max_q;
        end else if (miss_d) begin
            combo_d = 8'd0;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (!reset) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            prev_q  <= 4'd0;
            mask_q  <= 4'd0;
            state_q <= S_IDLE;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= 16'd0;
            combo_q <= 8'd0;
            max_q   <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign hit        = hit_q;
    assign note_clear = hit_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: hit/miss judging, scoring, saturation and reset priority.
module tb_note_judge;

    logic        CLOCK_25 = 1'b0;
    logic        reset;
    logic        note_new;
    logic [3:0]  note_cmd;
    logic [7:0]  note_y;
    logic [3:0]  btn;
    logic        hit, miss, note_clear;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;

    int total = 0;
    int bad   = 0;

    note_judge dut (
        .CLOCK_25  (CLOCK_25),
        .reset     (reset),
        .note_new  (note_new),
        .note_cmd  (note_cmd),
        .note_y    (note_y),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .note_clear(note_clear),
        .score     (score),
        .combo     (combo),
        .max_combo (max_combo)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    // Pulses btn for one cycle, then waits until the judgment is visible.
    task automatic press(input logic [3:0] m);
        btn = m;
        tick();
        btn = 4'd0;
        tick();
        tick();
    endtask

    task automatic arm(input logic [3:0] cmd, input logic [7:0] y);
        note_cmd = cmd;
        note_y   = y;
        note_new = 1'b1;
        tick();
        note_new = 1'b0;
    endtask

    task automatic do_hit();
        arm(4'b0001, 8'd40);
        press(4'b0001);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({hit, miss, note_clear, score, combo, max_combo} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got hit=%b miss=%b clr=%b score=%0d combo=%0d max=%0d, want all 0",
                     hit, miss, note_clear, score, combo, max_combo);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_hit();
        arm(4'b0001, 8'd200);
        for (int y = 199; y >= 43; y--) begin
            note_y = 8'(y);
            tick();
        end
        note_y = 8'd42;
        btn    = 4'b0001;
        tick();
        btn    = 4'd0;
        note_y = 8'd41;
        tick();
        total++;
        if (hit !== 1'b0) begin
            bad++;
            $display("FAIL hit_early: hit=%b after 2 edges, want 0", hit);
        end
        note_y = 8'd40;
        tick();
        total++;
        if ({hit, note_clear, miss} !== 3'b110) begin
            bad++;
            $display("FAIL hit_latency: hit/clr/miss=%b%b%b, want 110", hit, note_clear, miss);
        end
        total++;
        if ({score, combo, max_combo} !== {16'd10, 8'd1, 8'd1}) begin
            bad++;
            $display("FAIL hit_counters: score=%0d combo=%0d max=%0d, want 10 1 1", score, combo, max_combo);
        end
        tick();
        total++;
        if (hit !== 1'b0) begin
            bad++;
            $display("FAIL hit_one_cycle: hit=%b, want 0", hit);
        end
    endtask

    task automatic test_chord();
        arm(4'b0110, 8'd45);
        press(4'b0010);
        total++;
        if ({hit, miss} !== 2'b00) begin
            bad++;
            $display("FAIL chord_partial: hit/miss=%b%b, want 00", hit, miss);
        end
        note_y = 8'd38;
        press(4'b0100);
        total++;
        if ({hit, miss, score, combo} !== {2'b10, 16'd20, 8'd2}) begin
            bad++;
            $display("FAIL chord_complete: hit=%b miss=%b score=%0d combo=%0d, want 1 0 20 2", hit, miss, score, combo);
        end
        arm(4'b0110, 8'd40);
        press(4'b0110);
        total++;
        if ({hit, score} !== {1'b1, 16'd30}) begin
            bad++;
            $display("FAIL chord_simul: hit=%b score=%0d, want 1 30", hit, score);
        end
        tick();
        total++;
        if ({hit, miss} !== 2'b00) begin
            bad++;
            $display("FAIL chord_single_pulse: hit/miss=%b%b, want 00", hit, miss);
        end
    endtask

    task automatic test_passed_miss();
        arm(4'b0001, 8'd33);
        tick();
        note_y = 8'd32;
        tick();
        total++;
        if (miss !== 1'b0) begin
            bad++;
            $display("FAIL passed_edge32: miss=%b at window edge, want 0", miss);
        end
        note_y = 8'd31;
        tick();
        total++;
        if ({miss, hit, score, combo, max_combo} !== {2'b10, 16'd30, 8'd0, 8'd3}) begin
            bad++;
            $display("FAIL passed_miss: miss=%b hit=%b score=%0d combo=%0d max=%0d, want 1 0 30 0 3",
                     miss, hit, score, combo, max_combo);
        end
        note_y = 8'd40;
        press(4'b0001);
        total++;
        if ({hit, miss, score} !== {2'b00, 16'd30}) begin
            bad++;
            $display("FAIL judged_ignore: hit=%b miss=%b score=%0d, want 0 0 30", hit, miss, score);
        end
    endtask

    task automatic test_wrong_lane();
        test_reset();
        for (int i = 0; i < 5; i++) do_hit();
        arm(4'b0001, 8'd100);
        press(4'b0001);
        total++;
        if ({hit, miss} !== 2'b00) begin
            bad++;
            $display("FAIL early_ignore: hit/miss=%b%b above window, want 00", hit, miss);
        end
        note_y = 8'd40;
        press(4'b1000);
        total++;
        if ({miss, hit, combo, max_combo, score} !== {2'b10, 8'd0, 8'd5, 16'd50}) begin
            bad++;
            $display("FAIL wrong_lane: miss=%b hit=%b combo=%0d max=%0d score=%0d, want 1 0 0 5 50",
                     miss, hit, combo, max_combo, score);
        end
    endtask

    task automatic test_saturation();
        test_reset();
        for (int i = 0; i < 255; i++) do_hit();
        total++;
        if (combo !== 8'd255) begin
            bad++;
            $display("FAIL combo_255: combo=%0d, want 255", combo);
        end
        do_hit();
        total++;
        if ({combo, max_combo, score} !== {8'd255, 8'd255, 16'd2560}) begin
            bad++;
            $display("FAIL combo_sat: combo=%0d max=%0d score=%0d, want 255 255 2560", combo, max_combo, score);
        end
        for (int i = 0; i < 6297; i++) do_hit();
        total++;
        if (score !== 16'd65530) begin
            bad++;
            $display("FAIL score_pre_sat: score=%0d, want 65530", score);
        end
        do_hit();
        total++;
        if ({hit, score} !== {1'b1, 16'hFFFF}) begin
            bad++;
            $display("FAIL score_sat: hit=%b score=%0d, want 1 65535", hit, score);
        end
        do_hit();
        total++;
        if ({hit, score} !== {1'b1, 16'hFFFF}) begin
            bad++;
            $display("FAIL score_hold: hit=%b score=%0d, want 1 65535", hit, score);
        end
    endtask

    task automatic test_back_to_back();
        arm(4'b0001, 8'd100);
        tick();
        note_new = 1'b1;
        tick();
        note_new = 1'b0;
        total++;
        if ({miss, hit, combo} !== {2'b10, 8'd0}) begin
            bad++;
            $display("FAIL rearm_miss: miss=%b hit=%b combo=%0d, want 1 0 0", miss, hit, combo);
        end
        note_y = 8'd40;
        press(4'b0001);
        total++;
        if ({hit, combo} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL rearm_hit: hit=%b combo=%0d, want 1 1", hit, combo);
        end
    endtask

    task automatic test_reset_mid();
        arm(4'b0001, 8'd40);
        btn = 4'b0001;
        tick();
        btn   = 4'd0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++;
        if ({hit, miss, score, combo, max_combo} !== 34'd0) begin
            bad++;
            $display("FAIL reset_mid: hit=%b miss=%b score=%0d combo=%0d max=%0d, want all 0",
                     hit, miss, score, combo, max_combo);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({hit, miss, note_clear} !== 3'b000) begin
                bad++;
                $display("FAIL reset_no_pulse: cycle %0d hit/miss/clr=%b%b%b, want 000", i, hit, miss, note_clear);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        note_new = 1'b0;
        note_cmd = 4'd0;
        note_y   = 8'd200;
        btn      = 4'd0;
        test_reset();
        test_single_hit();
        test_chord();
        test_passed_miss();
        test_wrong_lane();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
